// File: rtl/l1pa_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : l1pa_seq_ctrl
//  Description : L1PA page sequencer. Loads shift-pattern pages into the
//                regType0 register file from a valid/ready stream, then on
//                start walks a contiguous (wrapping) window of pages and emits
//                the low SW bits of each page as an l1pa shift pattern.
//  Optional    : define L1PA_SEQ_REPEAT_EN to add repeat_i / stop_i
//                (continuous multi-pass operation until stopped).
//  Ports       :
//    sys_clk, rst                    clock, asynchronous active-high reset
//    cfg_valid_i/data_i/last_i       page-load stream in
//    cfg_ready_o                     page-load stream ready
//    regType0_waddr_o/wdata_o/we_o   register-file write port
//    start_i, seq_base_i, seq_len_i  sequence launch
//    rd_addr_o, page_rd_data_i       register-file read port (1-cycle latency)
//    l1pa_shift_o, shift_valid_o     shift pattern output
//    isGtr_o                         marks the last pattern of a pass
//    busy_o, done_o, err_o           status (err_o is sticky)
//    repeat_i, stop_i                only with L1PA_SEQ_REPEAT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module l1pa_seq_ctrl #(
    parameter  int SHARE_GROUP_SIZE = 5,
    parameter  int REGFILE_PAGE_NUM = 8,
    parameter  int PAGE_WIDTH       = 16,
    localparam int AW               = $clog2(REGFILE_PAGE_NUM),
    localparam int SW               = ($clog2(SHARE_GROUP_SIZE) < 1) ? 1 : $clog2(SHARE_GROUP_SIZE)
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  cfg_valid_i,
    input  logic [PAGE_WIDTH-1:0] cfg_data_i,
    input  logic                  cfg_last_i,
    output logic                  cfg_ready_o,
    output logic [AW-1:0]         regType0_waddr_o,
    output logic [PAGE_WIDTH-1:0] regType0_wdata_o,
    output logic                  regType0_we_o,
    input  logic                  start_i,
    input  logic [AW-1:0]         seq_base_i,
    input  logic [AW:0]           seq_len_i,
`ifdef L1PA_SEQ_REPEAT_EN
    input  logic                  repeat_i,
    input  logic                  stop_i,
`endif
    output logic [AW-1:0]         rd_addr_o,
    input  logic [PAGE_WIDTH-1:0] page_rd_data_i,
    output logic [SW-1:0]         l1pa_shift_o,
    output logic                  shift_valid_o,
    output logic                  isGtr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [1:0]  c_stIdle  = 2'd0;
    localparam logic [1:0]  c_stLoad  = 2'd1;
    localparam logic [1:0]  c_stRun   = 2'd2;
    localparam logic [1:0]  c_stFlush = 2'd3;
    localparam logic [AW:0] c_pageNum = (AW+1)'(REGFILE_PAGE_NUM);
    localparam logic [AW:0] c_one     = (AW+1)'(1);

    logic [1:0]  r_state;
    logic [1:0]  w_nextState;
    logic [AW:0] r_wCnt;       // beats accepted in this load, saturates at page count
    logic        r_loaded;
    logic [AW-1:0] r_base;
    logic [AW:0] r_len;
    logic [AW-1:0] r_rPtr;
    logic [AW:0] r_cnt;
    logic        r_issue;      // a read was issued last cycle
    logic        r_issueLast;  // ...and it was the last read of a pass
    logic        r_err;
    logic        r_rep;
    logic        r_stopReq;

    logic w_cfgReady;
    logic w_beat;
    logic w_excess;
    logic w_startOk;
    logic w_startErr;
    logic w_passEnd;
    logic w_reload;
    logic w_repeatIn;
    logic w_stopIn;
    logic w_unused_rdBits;

`ifdef L1PA_SEQ_REPEAT_EN
    assign w_repeatIn = repeat_i;
    assign w_stopIn   = stop_i;
`else
    assign w_repeatIn = 1'b0;
    assign w_stopIn   = 1'b0;
`endif

    // Ready is forced low while reset is held, independent of state.
    assign w_cfgReady = ((r_state == c_stIdle) || (r_state == c_stLoad)) && !rst;
    assign w_beat     = cfg_valid_i && w_cfgReady;
    assign w_excess   = (r_wCnt == c_pageNum);
    // A same-cycle config beat wins over start.
    assign w_startOk  = (r_state == c_stIdle) && start_i && !w_beat && r_loaded;
    assign w_startErr = (r_state == c_stIdle) && start_i && !w_beat && !r_loaded;
    assign w_passEnd  = (r_state == c_stRun) && (r_cnt == c_one);
    // A stop seen in the last cycle of a pass still ends the sequence there.
    assign w_reload   = w_passEnd && r_rep && !r_stopReq && !w_stopIn;
    assign w_unused_rdBits = ^page_rd_data_i;

    // ---------------------------------------------------------------- state
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= c_stIdle;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle: begin
                if (w_beat)
                    w_nextState = cfg_last_i ? c_stIdle : c_stLoad;
                else if (w_startOk)
                    w_nextState = (seq_len_i == '0) ? c_stFlush : c_stRun;
            end
            c_stLoad: begin
                if (w_beat && cfg_last_i) w_nextState = c_stIdle;
            end
            c_stRun: begin
                if (w_passEnd && !w_reload) w_nextState = c_stFlush;
            end
            default: w_nextState = c_stIdle;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_wCnt      <= '0;
            r_loaded    <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_rPtr      <= '0;
            r_cnt       <= '0;
            r_issue     <= 1'b0;
            r_issueLast <= 1'b0;
            r_err       <= 1'b0;
            r_rep       <= 1'b0;
            r_stopReq   <= 1'b0;
        end else begin
            if (w_beat) begin
                if (cfg_last_i)     r_wCnt <= '0;
                else if (!w_excess) r_wCnt <= r_wCnt + c_one;
                if (cfg_last_i)     r_loaded <= 1'b1;
            end
            if ((w_beat && w_excess) || w_startErr) r_err <= 1'b1;

            if (w_startOk) begin
                r_base    <= seq_base_i;
                r_len     <= seq_len_i;
                r_rPtr    <= seq_base_i;
                r_cnt     <= seq_len_i;
                r_rep     <= w_repeatIn;
                r_stopReq <= 1'b0;
            end else if (r_state == c_stRun) begin
                if (w_stopIn) r_stopReq <= 1'b1;
                if (w_reload) begin
                    r_rPtr <= r_base;
                    r_cnt  <= r_len;
                end else begin
                    r_rPtr <= r_rPtr + 1'b1;   // wraps naturally: page count is a power of two
                    r_cnt  <= r_cnt - c_one;
                end
            end

            r_issue     <= (r_state == c_stRun);
            r_issueLast <= w_passEnd;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        cfg_ready_o      = w_cfgReady;
        regType0_we_o    = w_beat && !w_excess;
        regType0_waddr_o = regType0_we_o ? r_wCnt[AW-1:0] : '0;
        regType0_wdata_o = regType0_we_o ? cfg_data_i : '0;
        rd_addr_o        = (r_state == c_stRun) ? r_rPtr : '0;
        shift_valid_o    = r_issue;
        l1pa_shift_o     = r_issue ? page_rd_data_i[SW-1:0] : '0;
        isGtr_o          = r_issue && r_issueLast;
        busy_o           = (r_state == c_stRun) || (r_state == c_stFlush);
        done_o           = (r_state == c_stFlush);
        err_o            = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_l1pa_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1pa_seq_ctrl
//  Description : Scoreboard bench for l1pa_seq_ctrl. Stimulus pushes expected
//                writes / shift patterns / done pulses into queues; a monitor
//                on the falling edge pops and compares. A behavioural register
//                file closes the write/read loop so shift values reveal the
//                page addresses that were read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1pa_seq_ctrl;

    localparam int AW = 3;
    localparam int SW = 3;
    localparam int PW = 16;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic [PW-1:0] cfg_data_i = '0;
    logic          cfg_last_i = 1'b0;
    logic          cfg_ready_o;
    logic [AW-1:0] regType0_waddr_o;
    logic [PW-1:0] regType0_wdata_o;
    logic          regType0_we_o;
    logic          start_i = 1'b0;
    logic [AW-1:0] seq_base_i = '0;
    logic [AW:0]   seq_len_i = '0;
    logic          repeat_i = 1'b0;
    logic          stop_i = 1'b0;
    logic [AW-1:0] rd_addr_o;
    logic [PW-1:0] page_rd_data_i = '0;
    logic [SW-1:0] l1pa_shift_o;
    logic          shift_valid_o;
    logic          isGtr_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int failures = 0;

    logic [AW+PW-1:0] wrQ[$];
    logic [SW:0]      shQ[$];
    int               doneQ[$];
    logic [PW-1:0]    mem[8];
    logic             prevDone = 1'b0;

    always #5 sys_clk = ~sys_clk;

    l1pa_seq_ctrl dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .cfg_valid_i      (cfg_valid_i),
        .cfg_data_i       (cfg_data_i),
        .cfg_last_i       (cfg_last_i),
        .cfg_ready_o      (cfg_ready_o),
        .regType0_waddr_o (regType0_waddr_o),
        .regType0_wdata_o (regType0_wdata_o),
        .regType0_we_o    (regType0_we_o),
        .start_i          (start_i),
        .seq_base_i       (seq_base_i),
        .seq_len_i        (seq_len_i),
`ifdef L1PA_SEQ_REPEAT_EN
        .repeat_i         (repeat_i),
        .stop_i           (stop_i),
`endif
        .rd_addr_o        (rd_addr_o),
        .page_rd_data_i   (page_rd_data_i),
        .l1pa_shift_o     (l1pa_shift_o),
        .shift_valid_o    (shift_valid_o),
        .isGtr_o          (isGtr_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    // Register file model: write-through on we, registered read.
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge sys_clk) begin
        if (regType0_we_o) mem[regType0_waddr_o] <= regType0_wdata_o;
        page_rd_data_i <= mem[rd_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (regType0_we_o) begin
                if (wrQ.size() == 0) chk("write_unexpected", 1, 0);
                else chk("write_addr_data", {regType0_waddr_o, regType0_wdata_o}, wrQ.pop_front());
            end
            if (shift_valid_o) begin
                if (shQ.size() == 0) chk("shift_unexpected", 1, 0);
                else chk("shift_gtr_pattern", {isGtr_o, l1pa_shift_o}, shQ.pop_front());
            end else if (isGtr_o) begin
                chk("isGtr_without_valid", 1, 0);
            end
            if (done_o) begin
                chk("done_single_cycle", prevDone, 0);
                if (doneQ.size() == 0) chk("done_unexpected", 1, 0);
                else void'(doneQ.pop_front());
            end
            prevDone = done_o;
        end else begin
            prevDone = 1'b0;
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        chk("rst_ready_low", cfg_ready_o, 0);
        chk("rst_outputs_zero", {regType0_we_o, regType0_waddr_o, regType0_wdata_o, rd_addr_o,
                                 l1pa_shift_o, shift_valid_o, isGtr_o, busy_o, done_o, err_o}, 0);
        cyc(2);
        rst = 1'b0;
        #1;
        chk("ready_after_release", cfg_ready_o, 1);
        wrQ.delete(); shQ.delete(); doneQ.delete();
        cyc(1);
    endtask

    task automatic beat(input logic [PW-1:0] d, input logic last, input logic expWr, input int addr);
        if (expWr) wrQ.push_back({addr[AW-1:0], d});
        cfg_valid_i = 1'b1; cfg_data_i = d; cfg_last_i = last;
        cyc(1);
        cfg_valid_i = 1'b0; cfg_data_i = '0; cfg_last_i = 1'b0;
    endtask

    task automatic loadFull();
        for (int i = 0; i < 8; i++) beat(16'(16'h0101 * i), i == 7, 1'b1, i);
    endtask

    task automatic startSeq(input int base, input int len, input logic rep);
        seq_base_i = base[AW-1:0]; seq_len_i = len[AW:0]; repeat_i = rep; start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    // Pushes expected patterns (low 3 bits of page k equal k) then runs one pass.
    task automatic runSeq(input int base, input int len);
        for (int i = 0; i < len; i++) shQ.push_back({i == len - 1, 3'((base + i) % 8)});
        doneQ.push_back(1);
        startSeq(base, len, 1'b0);
        chk("busy_after_start", busy_o, 1);
        cyc(len + 3);
        chk("shift_queue_drained", shQ.size(), 0);
        chk("done_queue_drained", doneQ.size(), 0);
        chk("idle_after_seq", busy_o, 0);
    endtask

    initial begin
        #1;
        // A: short 5-beat load, then a 2-page sequence from it
        doReset();
        for (int i = 0; i < 5; i++) beat(16'(i), i == 4, 1'b1, i);
        chk("write_queue_drained_5", wrQ.size(), 0);
        chk("err_after_5_beats", err_o, 0);
        runSeq(0, 2);

        // B: start without any load
        doReset();
        startSeq(2, 3, 1'b0);
        chk("err_start_unloaded", err_o, 1);
        chk("busy_start_unloaded", busy_o, 0);
        cyc(2);
        chk("busy_stays_low", busy_o, 0);
        chk("err_sticky", err_o, 1);

        // C: overflow, 9 beats before last
        doReset();
        for (int i = 0; i < 9; i++) beat(16'(16'h1000 + i), 1'b0, i < 8, i);
        chk("write_queue_drained_9", wrQ.size(), 0);
        chk("err_after_overflow", err_o, 1);
        chk("ready_during_overflow", cfg_ready_o, 1);
        beat(16'h1FFF, 1'b1, 1'b0, 0);

        // D: full load, windows, wrap, zero length, config priority
        doReset();
        loadFull();
        chk("err_after_full_load", err_o, 0);
        runSeq(3, 4);
        runSeq(6, 4);
        doneQ.push_back(1);
        startSeq(5, 0, 1'b0);
        chk("len0_busy", busy_o, 1);
        chk("len0_done", done_o, 1);
        cyc(3);
        chk("len0_done_drained", doneQ.size(), 0);
        // start alongside a config beat: beat wins, start ignored
        wrQ.push_back({3'd0, 16'h0000});
        cfg_valid_i = 1'b1; cfg_data_i = 16'h0000; cfg_last_i = 1'b1; start_i = 1'b1;
        cyc(1);
        cfg_valid_i = 1'b0; cfg_last_i = 1'b0; start_i = 1'b0;
        chk("start_lost_to_cfg", busy_o, 0);
        cyc(2);

        // E: reset in the 2nd RUN cycle
        startSeq(1, 4, 1'b0);
        cyc(1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", {regType0_we_o, rd_addr_o, shift_valid_o, isGtr_o, busy_o, done_o, cfg_ready_o}, 0);
        cyc(1);
        chk("midrun_rst_next_edge", {l1pa_shift_o, shift_valid_o, busy_o, done_o, err_o, rd_addr_o}, 0);
        rst = 1'b0;
        cyc(6);
        chk("midrun_no_late_output", busy_o, 0);

`ifdef L1PA_SEQ_REPEAT_EN
        // F: repeat with stop after the 4th pattern
        doReset();
        loadFull();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 3; i++) shQ.push_back({i == 2, 3'(i)});
        doneQ.push_back(1);
        startSeq(0, 3, 1'b1);
        cyc(3);
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        cyc(6);
        chk("repeat_shift_drained", shQ.size(), 0);
        chk("repeat_done_drained", doneQ.size(), 0);
        chk("repeat_idle", busy_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
